// File: rtl/n_body_sim.sv
// rtl/n_body_sim.sv - one pass of pairwise force accumulation over N bodies in an external two-port RAM
// Optional NBODY_SATURATE_EN: clamp forces to 16 bits instead of wrapping.
module n_body_sim #(
  parameter int N = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic [14:0] mem_rdaddress,
  input  logic [79:0] mem_q,
  output logic [14:0] mem_wraddress,
  output logic [79:0] mem_data,
  output logic        mem_wren
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_I = 3'd1;
  localparam logic [2:0] RD_J = 3'd2;
  localparam logic [2:0] ACC  = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] FIN  = 3'd5;

  localparam logic [14:0] LAST = 15'(N - 1);

  logic [2:0]         state;
  logic               wt;
  logic [14:0]        i;
  logic [14:0]        j;
  logic [47:0]        word_i;
  logic signed [47:0] acc_x;
  logic signed [47:0] acc_y;

  logic signed [16:0] dx, dy, mj;
  logic signed [33:0] px, py;
  logic signed [47:0] acc_x_nxt, acc_y_nxt;
  logic [15:0]        fx, fy;
  logic               unused_bits;

  assign unused_bits = ^mem_q[31:0];

  always_comb begin
    dx = $signed({mem_q[63], mem_q[63:48]}) - $signed({word_i[31], word_i[31:16]});
    dy = $signed({mem_q[47], mem_q[47:32]}) - $signed({word_i[15], word_i[15:0]});
    mj = $signed({1'b0, mem_q[79:64]});
    px = 34'(mj) * 34'(dx);
    py = 34'(mj) * 34'(dy);
    acc_x_nxt = acc_x;
    acc_y_nxt = acc_y;
    // The self term contributes nothing and is skipped outright.
    if (j != i) begin
      acc_x_nxt = acc_x + 48'(px >>> 8);
      acc_y_nxt = acc_y + 48'(py >>> 8);
    end
`ifdef NBODY_SATURATE_EN
    if (acc_x_nxt > 48'sd32767)       fx = 16'h7FFF;
    else if (acc_x_nxt < -48'sd32768) fx = 16'h8000;
    else                              fx = acc_x_nxt[15:0];
    if (acc_y_nxt > 48'sd32767)       fy = 16'h7FFF;
    else if (acc_y_nxt < -48'sd32768) fy = 16'h8000;
    else                              fy = acc_y_nxt[15:0];
`else
    fx = acc_x_nxt[15:0];
    fy = acc_y_nxt[15:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wt            <= 1'b0;
      done          <= 1'b0;
      mem_wren      <= 1'b0;
      mem_rdaddress <= '0;
      mem_wraddress <= '0;
      mem_data      <= '0;
      i             <= '0;
      j             <= '0;
      acc_x         <= '0;
      acc_y         <= '0;
      word_i        <= '0;
    end else begin
      mem_wren <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state         <= RD_I;
            wt            <= 1'b0;
            done          <= 1'b0;
            i             <= '0;
            mem_rdaddress <= '0;
          end
        end
        RD_I: begin
          // First cycle lets the RAM sample address i; second captures its word.
          if (!wt) begin
            wt <= 1'b1;
          end else begin
            wt            <= 1'b0;
            word_i        <= mem_q[79:32];
            acc_x         <= '0;
            acc_y         <= '0;
            j             <= '0;
            mem_rdaddress <= '0;
            state         <= RD_J;
          end
        end
        RD_J: state <= ACC;
        ACC: begin
          acc_x <= acc_x_nxt;
          acc_y <= acc_y_nxt;
          if (j == LAST) begin
            state         <= WR;
            mem_wren      <= 1'b1;
            mem_wraddress <= i;
            mem_data      <= {word_i, fx, fy};
          end else begin
            j             <= j + 15'd1;
            mem_rdaddress <= j + 15'd1;
            state         <= RD_J;
          end
        end
        WR: begin
          if (i == LAST) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            i             <= i + 15'd1;
            mem_rdaddress <= i + 15'd1;
            wt            <= 1'b0;
            state         <= RD_I;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n_body_sim.sv
// tb/tb_n_body_sim.sv - directed checks of n_body_sim with N=1, 2 and 3 against behavioural RAMs
module tb_n_body_sim;

  logic clk = 1'b0;
  logic reset;
  logic st1, st2, st3;
  logic done1, done2, done3;
  logic [14:0] rd1, rd2, rd3, wa1, wa2, wa3;
  logic [79:0] q1, q2, q3, wd1, wd2, wd3;
  logic wren1, wren2, wren3;

  logic [79:0] m1 [1];
  logic [79:0] m2 [2];
  logic [79:0] m3 [3];

  int n_checks = 0;
  int n_fail = 0;
  int cnt2 = 0, bad2 = 0, bad3 = 0, bad1 = 0;
  int base, cyc;

  always #5 clk = ~clk;

  n_body_sim #(.N(1)) dut1 (.clk(clk), .reset(reset), .start(st1), .done(done1),
    .mem_rdaddress(rd1), .mem_q(q1), .mem_wraddress(wa1), .mem_data(wd1), .mem_wren(wren1));
  n_body_sim #(.N(2)) dut2 (.clk(clk), .reset(reset), .start(st2), .done(done2),
    .mem_rdaddress(rd2), .mem_q(q2), .mem_wraddress(wa2), .mem_data(wd2), .mem_wren(wren2));
  n_body_sim #(.N(3)) dut3 (.clk(clk), .reset(reset), .start(st3), .done(done3),
    .mem_rdaddress(rd3), .mem_q(q3), .mem_wraddress(wa3), .mem_data(wd3), .mem_wren(wren3));

  always @(posedge clk) begin
    q1 <= (rd1 == 15'd0) ? m1[0] : '0;
    q2 <= (rd2 < 15'd2) ? m2[rd2[0]] : '0;
    q3 <= (rd3 < 15'd3) ? m3[rd3[1:0]] : '0;
    if (wren1) begin
      if (wa1 == 15'd0) m1[0] <= wd1; else bad1 = bad1 + 1;
    end
    if (wren2) begin
      cnt2 = cnt2 + 1;
      if (wa2 < 15'd2) m2[wa2[0]] <= wd2; else bad2 = bad2 + 1;
    end
    if (wren3) begin
      if (wa3 < 15'd3) m3[wa3[1:0]] <= wd3; else bad3 = bad3 + 1;
    end
  end

  function automatic logic [79:0] w(input int m, input int x, input int y, input int fx, input int fy);
    return {16'(m), 16'(x), 16'(y), 16'(fx), 16'(fy)};
  endfunction

  function automatic logic dn(input int k);
    case (k)
      1:       return done1;
      2:       return done2;
      default: return done3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse(input int k);
    @(posedge clk); #1;
    if (k == 1) st1 = 1'b1; else if (k == 2) st2 = 1'b1; else st3 = 1'b1;
    @(posedge clk); #1;
    st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
  endtask

  task automatic wait_done(input int k, output int cycles);
    cycles = 1;
    while (!dn(k) && cycles < 400) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run(input int k, input string tag, input int bound);
    int c;
    pulse(k);
    wait_done(k, c);
    check({tag, "_done"}, dn(k), 1'b1);
    check({tag, "_latency"}, (c <= bound), 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
    m1[0] = '0; m2[0] = '0; m2[1] = '0; m3[0] = '0; m3[1] = '0; m3[2] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done2, 1'b0);
    check("rst_wren", wren2, 1'b0);
    check("rst_rdaddr", rd2, 15'd0);
    check("rst_wraddr", wa2, 15'd0);
    check("rst_data", wd2, 80'd0);
    check("rst_done3", done3, 1'b0);
    reset = 1'b0;

    // Symmetric pair, unit-scaled mass
    m2[0] = w(256, 0, 0, 0, 0);
    m2[1] = w(256, 10, -4, 0, 0);
    base = cnt2;
    run(2, "pair", 2 * 8 + 4);
    check("pair_w0", m2[0], w(256, 0, 0, 10, -4));
    check("pair_w1", m2[1], w(256, 10, -4, -10, 4));
    check("pair_writes", cnt2 - base, 2);

    // Force overflow: 65535*32767>>>8 = 0x7FFE80
    m2[0] = w(1, 0, 0, 0, 0);
    m2[1] = w(65535, 32767, 0, 0, 0);
    run(2, "ovf", 2 * 8 + 4);
`ifdef NBODY_SATURATE_EN
    check("ovf_w0_fx", m2[0][31:16], 16'sd32767);
`else
    check("ovf_w0_fx", m2[0][31:16], 16'hFE80);
`endif
    check("ovf_w0_fy", m2[0][15:0], 16'd0);
    check("ovf_w1", m2[1], w(65535, 32767, 0, -128, 0));

    // Three bodies
    m3[0] = w(256, 0, 0, 0, 0);
    m3[1] = w(256, 4, 0, 0, 0);
    m3[2] = w(256, 0, 8, 0, 0);
    run(3, "tri", 3 * 10 + 4);
    check("tri_w0", m3[0], w(256, 0, 0, 4, 8));
    check("tri_w1", m3[1], w(256, 4, 0, -8, 8));
    check("tri_w2", m3[2], w(256, 0, 8, 4, -16));

    // Reset mid-pass, then a clean pass
    m2[0] = w(256, 0, 0, 0, 0);
    m2[1] = w(256, 10, -4, 0, 0);
    pulse(2);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_done", done2, 1'b0);
    check("midrst_wren", wren2, 1'b0);
    reset = 1'b0;
    m2[0] = w(256, 0, 0, 0, 0);
    m2[1] = w(256, 10, -4, 0, 0);
    base = cnt2;
    run(2, "after_rst", 2 * 8 + 4);
    check("after_rst_w0", m2[0], w(256, 0, 0, 10, -4));
    check("after_rst_w1", m2[1], w(256, 10, -4, -10, 4));
    check("after_rst_writes", cnt2 - base, 2);

    // Starts while busy are ignored; start in FIN reruns
    m2[0] = w(512, -6, 3, 99, 99);
    m2[1] = w(128, 2, -1, 99, 99);
    base = cnt2;
    pulse(2);
    repeat (2) @(posedge clk);
    pulse(2);
    repeat (2) @(posedge clk);
    pulse(2);
    wait_done(2, cyc);
    check("busy_done", done2, 1'b1);
    check("busy_writes", cnt2 - base, 2);
    // i=0: 128*8>>>8=4, 128*-4>>>8=-2 ; i=1: 512*-8>>>8=-16, 512*4>>>8=8
    check("busy_w0", m2[0], w(512, -6, 3, 4, -2));
    check("busy_w1", m2[1], w(128, 2, -1, -16, 8));
    pulse(2);
    check("fin_restart_done_low", done2, 1'b0);
    wait_done(2, cyc);
    check("fin_restart_done", done2, 1'b1);
    check("fin_restart_writes", cnt2 - base, 4);
    check("fin_restart_w1", m2[1], w(128, 2, -1, -16, 8));

    // Single body
    m1[0] = w(5, 7, -3, 11, 22);
    run(1, "single", 1 * 6 + 4);
    check("single_w0", m1[0], w(5, 7, -3, 0, 0));

    check("addr_range", bad1 + bad2 + bad3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
